// File: rtl/uart_tx_frame.sv
// UART transmitter: start + DATA_BITS (LSB first) + optional parity + 1/2 stop bits, paced by baud_tick.
// Define UART_TX_PARITY_EN to build the parity stage; without it parity_mode is ignored.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] din,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 o_ready,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_tx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state, state_next;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   cur_stop2;
    logic                   stop_second;
    logic                   done_q;
    logic                   hold_valid;
    logic [DATA_BITS-1:0]   hold_data;
    logic                   hold_stop2;
    logic                   bit_end;
    logic                   load;
    logic                   last_stop;
    logic                   accept;
    logic [DATA_BITS-1:0]   src_data;
    logic                   src_stop2;

`ifdef UART_TX_PARITY_EN
    logic [1:0]             hold_mode;
    logic [1:0]             src_mode;
    logic                   cur_par_en;
    logic                   par_bit;
    assign src_mode = hold_valid ? hold_mode : parity_mode;
`else
    logic                   unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    // A new frame takes the buffered entry if there is one, otherwise the live inputs
    // (only possible when an accept coincides with the final stop boundary).
    assign accept    = start && !hold_valid;
    assign src_data  = hold_valid ? hold_data : din;
    assign src_stop2 = hold_valid ? hold_stop2 : stop2;

    assign o_ready   = !hold_valid;
    assign o_tx_busy = (state != IDLE);
    assign o_tx_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        bit_end    = baud_tick && (state != IDLE) && (tick_cnt == TICK_LAST);
        load       = 1'b0;
        last_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && (bit_idx == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = cur_par_en ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_next = STOP;
`endif
            STOP: begin
                if (bit_end && (!cur_stop2 || stop_second)) begin
                    last_stop = 1'b1;
                    if (hold_valid || start) begin
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (state)
            START:   o_tx = 1'b0;
            DATA:    o_tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  o_tx = par_bit;
`endif
            default: o_tx = 1'b1;
        endcase
    end

    // The buffered entry is never overwritten; it frees on the edge its frame begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_stop2 <= 1'b0;
`ifdef UART_TX_PARITY_EN
            hold_mode  <= 2'b00;
`endif
        end else if (load && hold_valid) begin
            hold_valid <= 1'b0;
        end else if (accept && !load) begin
            hold_valid <= 1'b1;
            hold_data  <= din;
            hold_stop2 <= stop2;
`ifdef UART_TX_PARITY_EN
            hold_mode  <= parity_mode;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            cur_stop2   <= 1'b0;
            stop_second <= 1'b0;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            cur_par_en  <= 1'b0;
            par_bit     <= 1'b0;
`endif
        end else begin
            done_q <= last_stop;
            if (load) begin
                tick_cnt    <= '0;
                bit_idx     <= '0;
                shift_reg   <= src_data;
                cur_stop2   <= src_stop2;
                stop_second <= 1'b0;
`ifdef UART_TX_PARITY_EN
                cur_par_en  <= (src_mode == 2'b01) || (src_mode == 2'b10);
                par_bit     <= (src_mode == 2'b10) ? ~^src_data : ^src_data;
`endif
            end else if (bit_end) begin
                tick_cnt <= '0;
                if (state == DATA) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_ONE;
                end
                if (state == STOP) stop_second <= 1'b1;
            end else if (baud_tick && (state != IDLE)) begin
                tick_cnt <= tick_cnt + TICK_ONE;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a line monitor decodes each frame and pops the
// expected frame pushed by the driver at accept time. Follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_frame;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 3;

    typedef struct packed {
        logic [15:0] bits;
        logic [4:0]  nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick = 1'b0;
    logic       start;
    logic [7:0] din;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       o_ready, o_tx_busy, o_tx_done, o_tx;

    int     n_vectors = 0;
    int     n_miscompares = 0;
    frame_t exp_q[$];
    logic   in_frame = 1'b0;
    int     mon_ticks = 0;
    logic [15:0] mon_bits = '0;
    int     done_count = 0;
    logic   prev_done = 1'b0;
    int     tick_phase = 0;

    uart_tx_frame #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .start(start), .din(din),
        .parity_mode(parity_mode), .stop2(stop2), .o_ready(o_ready), .o_tx_busy(o_tx_busy),
        .o_tx_done(o_tx_done), .o_tx(o_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tick_phase = (tick_phase == TICK_DIV - 1) ? 0 : tick_phase + 1;
        baud_tick  = (tick_phase == 0);
    end

    function automatic frame_t model(input logic [7:0] d, input logic [1:0] pm, input logic s2);
        frame_t f;
        int n;
        f.bits = '0;
        n = 1;
        for (int i = 0; i < DATA_BITS; i++) begin
            f.bits[n] = d[i];
            n++;
        end
`ifdef UART_TX_PARITY_EN
        if (pm == 2'b01) begin
            f.bits[n] = ^d;
            n++;
        end else if (pm == 2'b10) begin
            f.bits[n] = ~^d;
            n++;
        end
`else
        if (pm == 2'b11) n = n + 0;
`endif
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = 5'(n);
        return f;
    endfunction

    // Line monitor: mon_ticks counts the tick about to land on the next rising edge,
    // and each bit is sampled just before its middle tick.
    always @(negedge clk) begin
        frame_t e;
        logic   exp_busy;
        if (!rst_n) begin
            in_frame  = 1'b0;
            mon_ticks = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                n_vectors++;
                if (o_tx_done !== 1'b0) begin
                    n_miscompares++;
                    $display("[TB] FAIL done_width: o_tx_done=%b required 0", o_tx_done);
                end
            end
            prev_done = o_tx_done;
            if (o_tx_done === 1'b1) begin
                done_count++;
                n_vectors++;
                if (!in_frame || exp_q.size() == 0) begin
                    n_miscompares++;
                    $display("[TB] FAIL unexpected_frame: in_frame=%b queued=%0d required a queued frame",
                             in_frame, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (mon_ticks !== int'(e.nbits) * OVERSAMPLE) begin
                        n_miscompares++;
                        $display("[TB] FAIL frame_len: ticks=%0d required %0d", mon_ticks,
                                 int'(e.nbits) * OVERSAMPLE);
                    end
                    n_vectors++;
                    if (mon_bits !== e.bits) begin
                        n_miscompares++;
                        $display("[TB] FAIL frame_bits: line=%b required %b", mon_bits, e.bits);
                    end
                    exp_busy = (exp_q.size() != 0);
                    n_vectors++;
                    if (o_tx_busy !== exp_busy) begin
                        n_miscompares++;
                        $display("[TB] FAIL busy_after_done: o_tx_busy=%b required %b", o_tx_busy, exp_busy);
                    end
                    if (exp_busy) begin
                        n_vectors++;
                        if ({o_tx, o_ready} !== 2'b01) begin
                            n_miscompares++;
                            $display("[TB] FAIL gapless_start: {o_tx,o_ready}=%b required 01", {o_tx, o_ready});
                        end
                    end
                end
                in_frame = 1'b0;
            end
            if (!in_frame && o_tx_busy === 1'b1) begin
                in_frame  = 1'b1;
                mon_ticks = 0;
                mon_bits  = '0;
            end
            if (in_frame && baud_tick) begin
                if ((mon_ticks % OVERSAMPLE) == OVERSAMPLE / 2 - 1 && (mon_ticks / OVERSAMPLE) < 16)
                    mon_bits[mon_ticks / OVERSAMPLE] = o_tx;
                mon_ticks++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic s2);
        int waited = 0;
        while (o_ready !== 1'b1 && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        n_vectors++;
        if (o_ready !== 1'b1) begin
            n_miscompares++;
            $display("[TB] FAIL ready_timeout: o_ready=%b required 1", o_ready);
        end
        start = 1'b1; din = d; parity_mode = pm; stop2 = s2;
        @(posedge clk); #1;
        exp_q.push_back(model(d, pm, s2));
        start = 1'b0;
        din = 8'($urandom);
        parity_mode = 2'($urandom);
        stop2 = 1'($urandom);
    endtask

    task automatic wait_ticks(input int n);
        int waited = 0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!(in_frame && mon_ticks >= n) && waited < 4000);
        n_vectors++;
        if (!(in_frame && mon_ticks >= n)) begin
            n_miscompares++;
            $display("[TB] FAIL tick_timeout: ticks=%0d required %0d", mon_ticks, n);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        while ((exp_q.size() != 0 || o_tx_busy !== 1'b0) && waited < 4000) begin
            @(negedge clk); #1;
            waited++;
        end
        n_vectors++;
        if (exp_q.size() != 0 || o_tx_busy !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL drain_timeout: queued=%0d busy=%b required 0/0", exp_q.size(), o_tx_busy);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vectors++;
        if ({o_tx, o_tx_busy, o_tx_done, o_ready} !== 4'b1001) begin
            n_miscompares++;
            $display("[TB] FAIL reset_state: {tx,busy,done,ready}=%b required 1001",
                     {o_tx, o_tx_busy, o_tx_done, o_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_vectors++;
        if ({o_tx, o_tx_busy, o_ready} !== 3'b101 || done_count != 0) begin
            n_miscompares++;
            $display("[TB] FAIL idle_ticks: {tx,busy,ready}=%b dones=%0d required 101/0",
                     {o_tx, o_tx_busy, o_ready}, done_count);
        end
    endtask

    task automatic test_single();
        send(8'hA5, 2'b00, 1'b0);
        @(posedge clk); #1;
        n_vectors++;
        if ({o_tx, o_tx_busy, o_ready} !== 3'b011) begin
            n_miscompares++;
            $display("[TB] FAIL start_latency: {tx,busy,ready}=%b required 011", {o_tx, o_tx_busy, o_ready});
        end
        wait_idle();
    endtask

    task automatic test_back_to_back(output int base);
        base = done_count;
        send(8'h3C, 2'b00, 1'b0);
        send(8'hC3, 2'b00, 1'b0);
        n_vectors++;
        if (o_ready !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL ready_full: o_ready=%b required 0", o_ready);
        end
        wait_ticks(150);
        n_vectors++;
        if (o_ready !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL ready_until_start: o_ready=%b required 0", o_ready);
        end
    endtask

    task automatic test_ignore_when_full(input int base);
        start = 1'b1; din = 8'hFF; parity_mode = 2'b00; stop2 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (600) @(posedge clk);
        #1;
        n_vectors++;
        if (done_count - base != 2) begin
            n_miscompares++;
            $display("[TB] FAIL frame_count: frames=%0d required 2", done_count - base);
        end
    endtask

    task automatic test_boundary_accept();
        int waited = 0;
        send(8'h55, 2'b00, 1'b0);
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!(in_frame && mon_ticks == 10 * OVERSAMPLE && baud_tick) && waited < 4000);
        start = 1'b1; din = 8'h96; parity_mode = 2'b00; stop2 = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(model(8'h96, 2'b00, 1'b1));
        start = 1'b0;
        wait_idle();
    endtask

    task automatic test_parity();
`ifdef UART_TX_PARITY_EN
        send(8'h07, 2'b01, 1'b0);
        wait_idle();
        send(8'h07, 2'b10, 1'b0);
        wait_idle();
        send(8'hB4, 2'b11, 1'b0);
        wait_idle();
`else
        send(8'h07, 2'b01, 1'b0);
        wait_idle();
        send(8'h07, 2'b10, 1'b0);
        wait_idle();
`endif
    endtask

    task automatic test_stop2();
        send(8'h00, 2'b00, 1'b1);
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic busy_seen = 1'b0;
        send(8'h00, 2'b00, 1'b0);
        send(8'hFF, 2'b00, 1'b0);
        wait_ticks(4 * OVERSAMPLE + 4);
        n_vectors++;
        if (o_tx !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL data_bit3: o_tx=%b required 0", o_tx);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vectors++;
        if ({o_tx, o_tx_busy, o_ready, o_tx_done} !== 4'b1010) begin
            n_miscompares++;
            $display("[TB] FAIL async_reset: {tx,busy,ready,done}=%b required 1010",
                     {o_tx, o_tx_busy, o_ready, o_tx_done});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        base = done_count;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_tx_busy !== 1'b0) busy_seen = 1'b1;
        end
        n_vectors++;
        if (busy_seen || done_count != base) begin
            n_miscompares++;
            $display("[TB] FAIL discard_buffer: busy_seen=%b frames=%0d required 0/0",
                     busy_seen, done_count - base);
        end
        @(posedge clk); #1;
        send(8'h81, 2'b00, 1'b0);
        wait_idle();
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; din = '0; parity_mode = 2'b00; stop2 = 1'b0;
        $display("[TB] uart_tx_frame bench start");
        test_reset();
        test_single();
        test_back_to_back(base);
        test_ignore_when_full(base);
        test_boundary_accept();
        test_parity();
        test_stop2();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
